imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory; the core's fetch path is the reader side.
- Receives a program as a byte stream with a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them to consecutive word addresses of the instruction memory write port.
- Holds the core in reset until the load completes, then releases it so execution starts at word 0.

Parameters:
- ADDR_WIDTH, 8, width of the instruction-memory word address.
- MAX_WORDS, 256, largest accepted program length in words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  one-cycle pulse that begins a new load.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write enable, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address for the write.
- mem_wdata  output  32  word to write.
- core_hold  output  1  active-high reset to the core; 1 = core held.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully; level signal.
- error  output  1  last load rejected (length > MAX_WORDS); level signal.
- words_loaded  output  16  count of words written in the current/last load.

Behaviour:
- Transfer rule: a byte is consumed on a rising edge where byte_valid & byte_ready = 1. byte_data is ignored otherwise.
- Reset (reset=0 at an edge) sets:
  - state IDLE;
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - core_hold=1, busy=0, done=0, error=0, words_loaded=0.
  - Reset overrides start and any in-flight handshake. A reset during a load writes nothing further.
- Stream format:
  - byte 0 = N[7:0], byte 1 = N[15:8], where N is the word count;
  - then 4·N bytes, least-significant byte of each word first.
- IDLE: byte_ready=0. start=1 → HDR0 and sets busy=1, core_hold=1, done=0, error=0, words_loaded=0, word index=0.
- HDR0: byte_ready=1. On transfer, latch N low byte → HDR1.
- HDR1: byte_ready=1. On transfer, latch N high byte, then evaluate:
  - N=0 → DONE;
  - N > MAX_WORDS → ERR;
  - otherwise → DATA with byte lane=0.
- DATA: byte_ready=1. On transfer, place the byte into lane (0..3) of the word shift register and increment lane. On lane 3, → WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_we=1, mem_addr=word index, mem_wdata=assembled word;
  - at the end of the cycle, word index and words_loaded increment;
  - → DONE if words_loaded becomes N, else → DATA with lane=0.
- Timing: mem_we asserts the cycle after the 4th byte of a word is accepted. The minimum load is 2 + 5·N cycles after start.
- DONE: busy=0, done=1, core_hold=0 (the core starts the following cycle), byte_ready=0.
- ERR: busy=0, error=1, core_hold stays 1, byte_ready=0. No memory write has occurred.
- start in IDLE, DONE or ERR restarts the load as described under IDLE; core_hold returns to 1 the next cycle.
- start while busy (HDR0/HDR1/DATA/WRITE) is ignored.
- byte_valid stalls of any length are allowed in every receiving state; state holds.
- mem_we=0 in every state except WRITE. mem_addr and mem_wdata hold their last values outside WRITE.
- Word index is ADDR_WIDTH bits. N ≤ MAX_WORDS guarantees no wrap-around.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 and byte_valid=1 → core_hold=1, busy=0, done=0, byte_ready=0, mem_we=0; after release, state is IDLE.
- Basic load: start, then stream 02 00 13 05 A0 00 93 05 50 00 → writes 0x00A00513 at addr 0 and 0x00500593 at addr 1, one mem_we pulse each. Result: done=1, words_loaded=2, core_hold=0.
- Back-pressure from source: same stream with byte_valid deasserted for 3 cycles between every byte → identical writes and final state; no extra or duplicate mem_we.
- Zero length: stream 00 00 → DONE immediately after the 2nd byte, no mem_we, words_loaded=0, core_hold=0.
- Oversize: MAX_WORDS=256, stream 01 01 (N=257) → error=1, done=0, core_hold=1, no mem_we. A following start plus a valid stream loads normally and clears error.
- Reset mid-load: reset=0 after the 2nd data byte of word 1 → no write for word 1, core_hold=1, state IDLE. A restart then loads from addr 0; start pulses while busy have no effect.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed little-endian byte stream and writes it as
// 32-bit words to consecutive addresses. The core is held in reset until the load completes.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        DONE,
        ERR
    } loaderState;

    localparam logic [15:0] MaxWords = 16'(MAX_WORDS);

    loaderState            state;
    logic [15:0]           wordCount;
    logic [ADDR_WIDTH-1:0] wordIndex;
    logic [1:0]            lane;
    logic [23:0]           shiftReg;

    logic        transfer;
    logic [15:0] headerLen;
    logic [15:0] nextLoaded;

    assign transfer   = byte_valid & byte_ready;
    assign headerLen  = {byte_data, wordCount[7:0]};
    assign nextLoaded = words_loaded + 16'd1;

    // NOTE: every output is a register, so each transition also loads the outputs the target state presents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state        <= IDLE;
            byte_ready   <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_hold    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            wordCount    <= '0;
            wordIndex    <= '0;
            lane         <= '0;
            shiftReg     <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= HDR0;
                        byte_ready   <= 1'b1;
                        busy         <= 1'b1;
                        core_hold    <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        wordIndex    <= '0;
                    end
                end

                HDR0: begin
                    if (transfer) begin
                        wordCount[7:0] <= byte_data;
                        state          <= HDR1;
                    end
                end

                HDR1: begin
                    if (transfer) begin
                        wordCount <= headerLen;
                        if (headerLen == 16'd0) begin
                            state      <= DONE;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            core_hold  <= 1'b0;
                        end else if (headerLen > MaxWords) begin
                            state      <= ERR;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            error      <= 1'b1;
                        end else begin
                            state <= DATA;
                            lane  <= '0;
                        end
                    end
                end

                DATA: begin
                    if (transfer) begin
                        case (lane)
                            2'd0: shiftReg[7:0]   <= byte_data;
                            2'd1: shiftReg[15:8]  <= byte_data;
                            2'd2: shiftReg[23:16] <= byte_data;
                            default: begin
                                state      <= WRITE;
                                byte_ready <= 1'b0;
                                mem_we     <= 1'b1;
                                mem_addr   <= wordIndex;
                                mem_wdata  <= {byte_data, shiftReg};
                            end
                        endcase
                        lane <= lane + 2'd1;
                    end
                end

                WRITE: begin
                    mem_we       <= 1'b0;
                    wordIndex    <= wordIndex + ADDR_WIDTH'(1);
                    words_loaded <= nextLoaded;
                    lane         <= '0;
                    if (nextLoaded == wordCount) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                    end else begin
                        state      <= DATA;
                        byte_ready <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    mem_we     <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: drives byte streams on the falling edge and checks writes,
// status levels and handshake behaviour against hand-computed values.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } memWrite;

    memWrite writeLog[$];

    imem_loader #(
        .ADDR_WIDTH(8),
        .MAX_WORDS (256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .core_hold   (core_hold),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Every cycle with mem_we high is one logged write; a stretched pulse shows up as a duplicate.
    always @(negedge clk) begin
        if (mem_we === 1'b1) writeLog.push_back('{addr: mem_addr, data: mem_wdata});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic startPulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int waitCycles = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (waitCycles >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: byte %h not accepted within 50 cycles", b);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        repeat (2) @(negedge clk);
        checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL reset_core_hold: got %b want 1", core_hold); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_done_error: got %b%b want 00", done, error); end
        checks++; if (byte_ready !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_ready_we: got %b%b want 00", byte_ready, mem_we); end
        checks++; if (words_loaded !== 16'd0 || mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_counters: got %h/%h/%h want 0/0/0", words_loaded, mem_addr, mem_wdata);
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (byte_ready !== 1'b0 || busy !== 1'b0 || core_hold !== 1'b1) begin
            errors++; $display("FAIL reset_idle: ready/busy/hold got %b%b%b want 001", byte_ready, busy, core_hold);
        end
    endtask

    task automatic test_basic_load();
        logic [7:0] stream [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
        writeLog.delete();
        startPulse();
        checks++; if (busy !== 1'b1 || byte_ready !== 1'b1) begin errors++; $display("FAIL basic_start: busy/ready got %b%b want 11", busy, byte_ready); end
        for (int i = 0; i < 6; i++) sendByte(stream[i], 0);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd0 || mem_wdata !== 32'h00A00513) begin
            errors++; $display("FAIL basic_word0: we/addr/data got %b/%h/%h want 1/00/00a00513", mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || byte_ready !== 1'b1 || words_loaded !== 16'd1) begin
            errors++; $display("FAIL basic_after_word0: we/ready/count got %b/%b/%0d want 0/1/1", mem_we, byte_ready, words_loaded);
        end
        for (int i = 6; i < 10; i++) sendByte(stream[i], 0);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd1 || mem_wdata !== 32'h00500593) begin
            errors++; $display("FAIL basic_word1: we/addr/data got %b/%h/%h want 1/01/00500593", mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || core_hold !== 1'b0 || words_loaded !== 16'd2) begin
            errors++; $display("FAIL basic_done: done/busy/hold/count got %b/%b/%b/%0d want 1/0/0/2", done, busy, core_hold, words_loaded);
        end
        repeat (3) @(negedge clk);
        checks++; if (writeLog.size() !== 2) begin errors++; $display("FAIL basic_write_count: got %0d want 2", writeLog.size()); end
    endtask

    task automatic test_back_pressure();
        logic [7:0] stream [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
        writeLog.delete();
        startPulse();
        for (int i = 0; i < 10; i++) sendByte(stream[i], 3);
        checks++; if (writeLog.size() !== 2) begin errors++; $display("FAIL bp_write_count: got %0d want 2", writeLog.size()); end
        checks++; if (writeLog[0].addr !== 8'd0 || writeLog[0].data !== 32'h00A00513) begin
            errors++; $display("FAIL bp_write0: got %h:%h want 00:00a00513", writeLog[0].addr, writeLog[0].data);
        end
        checks++; if (writeLog[1].addr !== 8'd1 || writeLog[1].data !== 32'h00500593) begin
            errors++; $display("FAIL bp_write1: got %h:%h want 01:00500593", writeLog[1].addr, writeLog[1].data);
        end
        checks++; if (done !== 1'b1 || core_hold !== 1'b0 || words_loaded !== 16'd2) begin
            errors++; $display("FAIL bp_done: done/hold/count got %b/%b/%0d want 1/0/2", done, core_hold, words_loaded);
        end
    endtask

    task automatic test_zero_length();
        writeLog.delete();
        startPulse();
        checks++; if (core_hold !== 1'b1 || done !== 1'b0 || words_loaded !== 16'd0) begin
            errors++; $display("FAIL zero_restart: hold/done/count got %b/%b/%0d want 1/0/0", core_hold, done, words_loaded);
        end
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || core_hold !== 1'b0 || byte_ready !== 1'b0) begin
            errors++; $display("FAIL zero_done: done/busy/hold/ready got %b/%b/%b/%b want 1/0/0/0", done, busy, core_hold, byte_ready);
        end
        repeat (3) @(negedge clk);
        checks++; if (writeLog.size() !== 0 || words_loaded !== 16'd0) begin
            errors++; $display("FAIL zero_no_write: writes/count got %0d/%0d want 0/0", writeLog.size(), words_loaded);
        end
    endtask

    task automatic test_oversize();
        writeLog.delete();
        startPulse();
        sendByte(8'h01, 0);
        sendByte(8'h01, 0);
        checks++; if (error !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            errors++; $display("FAIL oversize_err: err/done/hold/busy/ready got %b/%b/%b/%b/%b want 1/0/1/0/0",
                               error, done, core_hold, busy, byte_ready);
        end
        repeat (3) @(negedge clk);
        checks++; if (writeLog.size() !== 0) begin errors++; $display("FAIL oversize_no_write: got %0d want 0", writeLog.size()); end
        startPulse();
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL oversize_restart: err/busy got %b/%b want 0/1", error, busy); end
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        sendByte(8'hEF, 0);
        sendByte(8'hBE, 1);
        sendByte(8'hAD, 0);
        sendByte(8'hDE, 0);
        repeat (2) @(negedge clk);
        checks++; if (writeLog.size() !== 1 || writeLog[0].addr !== 8'd0 || writeLog[0].data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL oversize_reload_write: n/addr/data got %0d/%h/%h want 1/00/deadbeef",
                               writeLog.size(), writeLog[0].addr, writeLog[0].data);
        end
        checks++; if (done !== 1'b1 || error !== 1'b0 || core_hold !== 1'b0 || words_loaded !== 16'd1) begin
            errors++; $display("FAIL oversize_reload_done: done/err/hold/count got %b/%b/%b/%0d want 1/0/0/1", done, error, core_hold, words_loaded);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] stream [8] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAA, 8'hBB};
        writeLog.delete();
        startPulse();
        for (int i = 0; i < 8; i++) sendByte(stream[i], 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if (core_hold !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0 || done !== 1'b0 || words_loaded !== 16'd0) begin
            errors++; $display("FAIL midreset_state: hold/busy/ready/done/count got %b/%b/%b/%b/%0d want 1/0/0/0/0",
                               core_hold, busy, byte_ready, done, words_loaded);
        end
        repeat (4) @(negedge clk);
        checks++; if (writeLog.size() !== 1 || writeLog[0].data !== 32'h12345678) begin
            errors++; $display("FAIL midreset_writes: n/data0 got %0d/%h want 1/12345678", writeLog.size(), writeLog[0].data);
        end
        writeLog.delete();
        startPulse();
        sendByte(8'h01, 0);
        startPulse();
        sendByte(8'h00, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        startPulse();
        sendByte(8'h33, 0);
        sendByte(8'h44, 0);
        repeat (2) @(negedge clk);
        checks++; if (writeLog.size() !== 1 || writeLog[0].addr !== 8'd0 || writeLog[0].data !== 32'h44332211) begin
            errors++; $display("FAIL midreset_reload: n/addr/data got %0d/%h/%h want 1/00/44332211",
                               writeLog.size(), writeLog[0].addr, writeLog[0].data);
        end
        checks++; if (done !== 1'b1 || core_hold !== 1'b0 || words_loaded !== 16'd1) begin
            errors++; $display("FAIL midreset_done: done/hold/count got %b/%b/%0d want 1/0/1", done, core_hold, words_loaded);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_back_pressure();
        test_zero_length();
        test_oversize();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
